// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer
//   Run-control FSM wrapped around an N-bit up-counter. A start command latches
//   the terminal value (limit) and the run mode (periodic), then the counter
//   steps 0..lim_q once per unpaused cycle. In one-shot mode the sequencer
//   parks in DONE holding the terminal value. In periodic mode it wraps to 0
//   and bumps a saturating wrap counter. Used for display refresh, blink rates
//   and sampling strobes.
//
// Parameters
//   N         width of count and limit
//   W         width of the saturating wrap counter
//
// Ports
//   clk       in   1  clock, all state updates on the rising edge
//   reset     in   1  synchronous, active-high reset
//   start     in   1  begin a run (sampled in IDLE and DONE only)
//   pause     in   1  level, freezes counting while high
//   stop      in   1  abort the run and return to IDLE
//   periodic  in   1  run mode latched at start: 1 = wrap, 0 = one-shot
//   limit     in   N  terminal value latched at start
//   count     out  N  current count (registered)
//   tc        out  1  terminal-count strobe
//   busy      out  1  state is RUN or HOLD
//   done      out  1  state is DONE
//   state     out  2  IDLE=0, RUN=1, HOLD=2, DONE=3
//   wrap_cnt  out  W  periodic wraps since the last start, saturating
// ----------------------------------------------------------------------------
module counter_sequencer #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         pause,
   input  logic         stop,
   input  logic         periodic,
   input  logic [N-1:0] limit,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         busy,
   output logic         done,
   output logic [1:0]   state,
   output logic [W-1:0] wrap_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]   state_q, state_d;
   logic [N-1:0] count_q, count_d;
   logic [N-1:0] lim_q,   lim_d;
   logic         per_q,   per_d;
   logic [W-1:0] wrap_q,  wrap_d;

   logic at_limit;
   logic wrap_full;

   assign at_limit  = (count_q == lim_q);
   assign wrap_full = (wrap_q == {W{1'b1}});

   always_comb begin
      // NOTE: every signal assigned below gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_d = state_q;
      count_d = count_q;
      lim_d   = lim_q;
      per_d   = per_q;
      wrap_d  = wrap_q;

      case (state_q)
         IDLE: begin
            // pause and stop have no meaning before a run exists.
            if (start) begin
               lim_d   = limit;
               per_d   = periodic;
               count_d = '0;
               wrap_d  = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            // stop beats pause beats counting; start is ignored mid-run.
            if (stop) begin
               count_d = '0;
               state_d = IDLE;
            end else if (pause) begin
               state_d = HOLD;
            end else if (!at_limit) begin
               count_d = count_q + N'(1);
            end else if (per_q) begin
               count_d = '0;
               if (!wrap_full) wrap_d = wrap_q + W'(1);
            end else begin
               // One-shot: park with count left at the terminal value.
               state_d = DONE;
            end
         end

         HOLD: begin
            // Count stays frozen; resuming costs one cycle back in RUN.
            if (stop) begin
               count_d = '0;
               state_d = IDLE;
            end else if (!pause) begin
               state_d = RUN;
            end
         end

         default: begin // DONE
            if (start) begin
               lim_d   = limit;
               per_d   = periodic;
               count_d = '0;
               wrap_d  = '0;
               state_d = RUN;
            end else if (stop) begin
               count_d = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         lim_q   <= '0;
         per_q   <= 1'b0;
         wrap_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lim_q   <= lim_d;
         per_q   <= per_d;
         wrap_q  <= wrap_d;
      end
   end

   // tc is qualified by the live pause/stop inputs so it never fires on a
   // cycle where the terminal step is not actually taken.
   assign tc       = (state_q == RUN) && at_limit && !pause && !stop;
   assign busy     = (state_q == RUN) || (state_q == HOLD);
   assign done     = (state_q == DONE);
   assign state    = state_q;
   assign count    = count_q;
   assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

   logic clk = 1'b0;
   logic reset, start, pause, stop, periodic;
   logic [7:0] limit;

   // Instance A: default widths N=8, W=8.
   logic [7:0] count_a, wrap_a;
   logic       tc_a, busy_a, done_a;
   logic [1:0] state_a;

   // Instance B: narrow widths N=3, W=2 for wrap and saturation corners.
   logic [2:0] count_b;
   logic [1:0] wrap_b, state_b;
   logic       tc_b, busy_b, done_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_sequencer #(.N(8), .W(8)) dut_a (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
      .periodic(periodic), .limit(limit), .count(count_a), .tc(tc_a),
      .busy(busy_a), .done(done_a), .state(state_a), .wrap_cnt(wrap_a)
   );

   counter_sequencer #(.N(3), .W(2)) dut_b (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
      .periodic(periodic), .limit(limit[2:0]), .count(count_b), .tc(tc_b),
      .busy(busy_b), .done(done_b), .state(state_b), .wrap_cnt(wrap_b)
   );

   logic [20:0] obs_a;
   logic [9:0]  obs_b;
   assign obs_a = {state_a, count_a, tc_a, busy_a, done_a, wrap_a};
   assign obs_b = {state_b, count_b, tc_b, busy_b, done_b, wrap_b};

   // ---------------------------------------------------------------- model
   // Behavioural reference: plain integers following the run-control rules.
   typedef struct {
      int st;    // 0 idle, 1 run, 2 hold, 3 done
      int cnt;
      int lim;
      int per;
      int wrap;
   } model_t;

   model_t ma, mb;

   function automatic model_t mstep(input model_t m, input int cmax, input int wmax);
      model_t r = m;
      if (reset) begin
         r.st = 0; r.cnt = 0; r.lim = 0; r.per = 0; r.wrap = 0;
      end else if ((m.st == 0 || m.st == 3) && start) begin
         r.st = 1; r.cnt = 0; r.wrap = 0;
         r.lim = int'(limit) % (cmax + 1);
         r.per = int'(periodic);
      end else if (m.st != 0 && stop) begin
         r.st = 0; r.cnt = 0;
      end else if (m.st == 1) begin
         if (pause) r.st = 2;
         else if (m.cnt < m.lim) r.cnt = m.cnt + 1;
         else if (m.per != 0) begin
            r.cnt  = 0;
            r.wrap = (m.wrap < wmax) ? m.wrap + 1 : wmax;
         end else r.st = 3;
      end else if (m.st == 2 && !pause) begin
         r.st = 1;
      end
      return r;
   endfunction

   function automatic logic [20:0] pk_a(input int st, input int cnt, input bit t, input int wrap);
      logic [1:0] s2 = 2'(st);
      return {s2, 8'(cnt), t, (st == 1 || st == 2), (st == 3), 8'(wrap)};
   endfunction

   function automatic logic [9:0] pk_b(input int st, input int cnt, input bit t, input int wrap);
      logic [1:0] s2 = 2'(st);
      return {s2, 3'(cnt), t, (st == 1 || st == 2), (st == 3), 2'(wrap)};
   endfunction

   function automatic bit model_tc(input model_t m);
      return (m.st == 1) && (m.cnt == m.lim) && !pause && !stop;
   endfunction

   // Advance one clock: the models see the same inputs the DUTs sampled.
   task automatic tick();
      @(posedge clk);
      ma = mstep(ma, 255, 255);
      mb = mstep(mb, 7, 3);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
   endtask

   task automatic launch(input int lim, input bit per);
      limit = 8'(lim); periodic = per; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic abort_run();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      reset = 1'b1; start = 1'b1; pause = 1'b0; stop = 1'b0;
      periodic = 1'b1; limit = 8'd5;
      tick(); tick();
      idle_inputs();
      #1;
      checks++;
      if (obs_a !== pk_a(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs_a, pk_a(0, 0, 0, 0));
      end
      tick();
      checks++;
      if (obs_b !== pk_b(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_idle_b: got %h expected %h", obs_b, pk_b(0, 0, 0, 0));
      end
   endtask

   task automatic test_oneshot();
      launch(3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs_a !== pk_a(1, i, (i == 3), 0)) begin
            errors++;
            $display("FAIL oneshot_step%0d: got %h expected %h", i, obs_a, pk_a(1, i, (i == 3), 0));
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (obs_a !== pk_a(3, 3, 0, 0)) begin
            errors++;
            $display("FAIL oneshot_done%0d: got %h expected %h", i, obs_a, pk_a(3, 3, 0, 0));
         end
         tick();
      end
      abort_run();
   endtask

   task automatic test_periodic();
      launch(2, 1'b1);
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (obs_a !== pk_a(1, i % 3, (i % 3 == 2), i / 3)) begin
            errors++;
            $display("FAIL periodic_step%0d: got %h expected %h", i, obs_a, pk_a(1, i % 3, (i % 3 == 2), i / 3));
         end
         tick();
      end
      abort_run();
      #1;
      checks++;
      if (obs_a !== pk_a(0, 0, 0, 2)) begin
         errors++;
         $display("FAIL periodic_stop: got %h expected %h", obs_a, pk_a(0, 0, 0, 2));
      end
   endtask

   task automatic test_pause();
      launch(5, 1'b0);
      tick();                          // count now 1
      pause = 1'b1;
      #1;
      checks++;
      if (obs_a !== pk_a(1, 1, 0, 0)) begin
         errors++;
         $display("FAIL pause_enter: got %h expected %h", obs_a, pk_a(1, 1, 0, 0));
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs_a !== pk_a(2, 1, 0, 0)) begin
            errors++;
            $display("FAIL pause_hold%0d: got %h expected %h", i, obs_a, pk_a(2, 1, 0, 0));
         end
      end
      pause = 1'b0;
      tick();
      checks++;
      if (obs_a !== pk_a(1, 1, 0, 0)) begin
         errors++;
         $display("FAIL pause_resume: got %h expected %h", obs_a, pk_a(1, 1, 0, 0));
      end
      tick();
      checks++;
      if (obs_a !== pk_a(1, 2, 0, 0)) begin
         errors++;
         $display("FAIL pause_count2: got %h expected %h", obs_a, pk_a(1, 2, 0, 0));
      end
      abort_run();
   endtask

   task automatic test_priority();
      launch(2, 1'b1);
      tick(); tick();                  // count == limit
      stop = 1'b1; pause = 1'b1;
      #1;
      checks++;
      if (tc_a !== 1'b0) begin
         errors++;
         $display("FAIL prio_stop_tc: got %0b expected 0", tc_a);
      end
      tick();
      stop = 1'b0; pause = 1'b0;
      checks++;
      if (obs_a !== pk_a(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL prio_stop_idle: got %h expected %h", obs_a, pk_a(0, 0, 0, 0));
      end
      launch(2, 1'b1);
      tick(); tick();
      pause = 1'b1;
      #1;
      checks++;
      if (tc_a !== 1'b0) begin
         errors++;
         $display("FAIL prio_pause_tc: got %0b expected 0", tc_a);
      end
      tick();
      checks++;
      if (obs_a !== pk_a(2, 2, 0, 0)) begin
         errors++;
         $display("FAIL prio_pause_hold: got %h expected %h", obs_a, pk_a(2, 2, 0, 0));
      end
      pause = 1'b0;
      tick();
      checks++;
      if (obs_a !== pk_a(1, 2, 1, 0)) begin
         errors++;
         $display("FAIL prio_resume_tc: got %h expected %h", obs_a, pk_a(1, 2, 1, 0));
      end
      tick();
      checks++;
      if (obs_a !== pk_a(1, 0, 0, 1)) begin
         errors++;
         $display("FAIL prio_wrap: got %h expected %h", obs_a, pk_a(1, 0, 0, 1));
      end
      abort_run();
   endtask

   task automatic test_boundaries();
      // Narrow instance: full-range limit wraps 7 -> 0, wrap_cnt saturates at 3.
      launch(7, 1'b1);
      for (int i = 0; i < 41; i++) begin
         #1;
         checks++;
         if (obs_b !== pk_b(1, i % 8, (i % 8 == 7), (i / 8 > 3) ? 3 : i / 8)) begin
            errors++;
            $display("FAIL narrow_wrap%0d: got %h expected %h", i, obs_b, pk_b(1, i % 8, (i % 8 == 7), (i / 8 > 3) ? 3 : i / 8));
         end
         tick();
      end
      abort_run();
      // limit = 0 periodic: tc every RUN cycle, count pinned at 0.
      launch(0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (obs_a !== pk_a(1, 0, 1, i)) begin
            errors++;
            $display("FAIL limit0_per%0d: got %h expected %h", i, obs_a, pk_a(1, 0, 1, i));
         end
         tick();
      end
      abort_run();
      // limit = 0 one-shot: single tc cycle then DONE.
      launch(0, 1'b0);
      tick();
      checks++;
      if (obs_a !== pk_a(3, 0, 0, 0)) begin
         errors++;
         $display("FAIL limit0_oneshot: got %h expected %h", obs_a, pk_a(3, 0, 0, 0));
      end
      abort_run();
      // Full 8-bit limit: 255 -> 0 without overflow.
      launch(255, 1'b1);
      for (int i = 0; i < 258; i++) begin
         #1;
         checks++;
         if (obs_a !== pk_a(1, i % 256, (i % 256 == 255), i / 256)) begin
            errors++;
            $display("FAIL limit255_%0d: got %h expected %h", i, obs_a, pk_a(1, i % 256, (i % 256 == 255), i / 256));
         end
         tick();
      end
      abort_run();
   endtask

   task automatic test_reset_mid_run();
      launch(9, 1'b1);
      tick(); tick();
      reset = 1'b1; start = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      #1;
      checks++;
      if (obs_a !== pk_a(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_mid_run: got %h expected %h", obs_a, pk_a(0, 0, 0, 0));
      end
      tick();
      checks++;
      if (obs_a !== pk_a(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_after: got %h expected %h", obs_a, pk_a(0, 0, 0, 0));
      end
   endtask

   task automatic test_done_restart();
      launch(1, 1'b0);
      tick(); tick();
      #1;
      checks++;
      if (obs_a !== pk_a(3, 1, 0, 0)) begin
         errors++;
         $display("FAIL restart_done: got %h expected %h", obs_a, pk_a(3, 1, 0, 0));
      end
      limit = 8'd0;                   // changes while parked are ignored
      periodic = 1'b1;
      tick();
      checks++;
      if (obs_a !== pk_a(3, 1, 0, 0)) begin
         errors++;
         $display("FAIL restart_hold: got %h expected %h", obs_a, pk_a(3, 1, 0, 0));
      end
      launch(4, 1'b0);
      for (int i = 0; i < 3; i++) begin
         limit = 8'(i);               // mid-run limit change must not matter
         #1;
         checks++;
         if (obs_a !== pk_a(1, i, 0, 0)) begin
            errors++;
            $display("FAIL restart_step%0d: got %h expected %h", i, obs_a, pk_a(1, i, 0, 0));
         end
         tick();
      end
      abort_run();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 99) == 0);
         start    = ($urandom_range(0, 9) < 2);
         pause    = ($urandom_range(0, 9) < 2);
         stop     = ($urandom_range(0, 19) == 0);
         periodic = $urandom_range(0, 1) == 1;
         limit    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 6));
         #1;
         checks++;
         if (obs_a !== pk_a(ma.st, ma.cnt, model_tc(ma), ma.wrap)) begin
            errors++;
            $display("FAIL random_a cycle %0d: got %h expected %h", i, obs_a, pk_a(ma.st, ma.cnt, model_tc(ma), ma.wrap));
         end
         checks++;
         if (obs_b !== pk_b(mb.st, mb.cnt, model_tc(mb), mb.wrap)) begin
            errors++;
            $display("FAIL random_b cycle %0d: got %h expected %h", i, obs_b, pk_b(mb.st, mb.cnt, model_tc(mb), mb.wrap));
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
      test_reset();
      test_oneshot();
      test_periodic();
      test_pause();
      test_priority();
      test_boundaries();
      test_reset_mid_run();
      test_done_restart();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
